pdatapath_sequencer: RTL and testbench
======================================

Name: pdatapath_sequencer

Overview:
- Instruction sequencer for the 8-bit pipelined-free datapath: replaces manual instruction injection with a program counter and instruction-memory fetch.
- Runs a multicycle FETCH/LATCH/EXEC/COMMIT loop.
- Drives the decoder's instruction input and the register-file/data-memory write strobe.
- Resolves branches from the ALU take_branch flag and stops on a HALT opcode; supports single-step (debounced pushbutton) and free-run.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- EXEC_CYCLES, 2, cycles spent in EXEC for datapath/memory settling; legal range 1..15.
- OPC_BRANCH, 4'b1000, opcode (instruction[15:12]) treated as conditional branch.
- OPC_HALT, 4'b1111, opcode that stops the sequencer.

Ports:
- clk  in  1  general clock
- rst_general  in  1  asynchronous active-high reset
- run  in  1  level: free-run when high
- step_pulse  in  1  one-cycle pulse (debounced PBN1): execute one instruction
- imem_addr  out  8  instruction memory address
- imem_data  in  16  instruction memory read data, valid 1 cycle after imem_addr
- take_branch  in  1  ALU branch condition, sampled in last EXEC cycle
- instruction  out  16  current instruction to decoder
- pc  out  8  current program counter
- reg_we_strobe  out  1  one-cycle commit pulse (gated externally with RegWrite/MemWrite)
- busy  out  1  high in FETCH, LATCH, EXEC, COMMIT
- halted  out  1  high in HALT state
- retired_count  out  16  retired-instruction counter (optional feature)

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state=IDLE, pc=RESET_PC, instruction=16'h0000.
  - reg_we_strobe=0, busy=0, halted=0, retired_count=0.
  - A reset during EXEC produces no strobe.
- imem_addr = pc combinationally at all times.
- States:
  - IDLE: if run or step_pulse -> FETCH; step_pulse is ignored in every other state.
  - FETCH: 1 cycle; memory read in flight -> LATCH.
  - LATCH: instruction <= imem_data -> EXEC; the exec counter loads EXEC_CYCLES-1.
  - EXEC: counts down to 0. In the final cycle it samples take_branch and evaluates the opcode -> COMMIT, or -> HALT if opcode==OPC_HALT.
  - COMMIT: 1 cycle, reg_we_strobe=1, pc updated at end of cycle. Next state is FETCH if run=1, else IDLE.
  - HALT: reg_we_strobe=0, pc unchanged (addresses the HALT word). Exits only on reset.
- PC update in COMMIT, all arithmetic 8-bit modulo 256:
  - If opcode==OPC_BRANCH and sampled take_branch=1: pc <= pc + 1 + sign-extended instruction[7:0].
  - Otherwise pc <= pc + 1.
  - Wrap: 8'hFF+1 -> 8'h00; a branch offset of 8'h80 from pc 8'h10 -> 8'h91.
- The strobe is asserted on branch commits as well; the decoder's RegWrite=0 suppresses the write.
- Latency: step_pulse sampled in IDLE at edge t gives FETCH t+1, LATCH t+2, EXEC t+3..t+2+EXEC_CYCLES, COMMIT t+3+EXEC_CYCLES (t+5 at default).
- Free-run throughput: 3+EXEC_CYCLES cycles per instruction.
- run falling mid-instruction: the current instruction completes through COMMIT, then the sequencer enters IDLE.
- step_pulse and run both high in IDLE: same as run.
- instruction holds its value between LATCH events, including through IDLE and HALT.

Optional Feature:
- Macro: PDATAPATH_SEQ_RETIRE_CNT_EN.
- Defined:
  - retired_count increments by 1 on each COMMIT cycle.
  - Saturates at 16'hFFFF.
  - HALT does not count.
  - Cleared only by reset.
- Undefined: retired_count tied to 16'h0000 and no counter flops are synthesized.

Test Plan:
- Reset then single step: ROM[0]=16'h1234, pulse step_pulse for one cycle at t. Expect instruction=16'h1234 from t+3, reg_we_strobe high exactly at t+5, then pc=8'h01, state IDLE, busy=0.
- Free run: ROM[0..2] non-branch, ROM[3]=OPC_HALT word, run=1. Expect strobes at 5-cycle spacing (3 total), pc stops at 8'h03, halted=1, no further strobes; with the macro defined, retired_count=3.
- Branch taken/not taken: pc=8'h05, instruction 16'h80FC (offset -4). With take_branch=1, pc becomes 8'h02; with take_branch=0, pc becomes 8'h06.
- Wrap-around: RESET_PC=8'hFF, non-branch at 8'hFF. After commit, pc=8'h00; a branch at 8'hF0 with offset 8'h20 taken gives pc=8'h11.
- Run drop and ignored step: deassert run during EXEC, and pulse step_pulse during EXEC. The current instruction commits once, the sequencer enters IDLE, and the step pulse has no effect.
- Reset mid-operation: assert rst_general in the EXEC cycle preceding COMMIT. Expect no strobe, pc=RESET_PC, instruction=16'h0000 immediately (asynchronously), halted=0.

Source files
------------

// File: rtl/pdatapath_sequencer.sv
// -----------------------------------------------------------------------------
// pdatapath_sequencer
//
// Instruction sequencer for the 8-bit datapath. It owns the program counter,
// fetches from the instruction memory, presents the instruction to the decoder
// and issues the single-cycle commit strobe. Each instruction moves through
// FETCH -> LATCH -> EXEC (EXEC_CYCLES cycles) -> COMMIT. Single-step is driven
// by step_pulse and free-run by run. A HALT opcode parks the sequencer until
// reset.
//
// Optional feature macro: PDATAPATH_SEQ_RETIRE_CNT_EN
//   defined   : retired_count counts COMMIT cycles and saturates at 16'hFFFF
//   undefined : retired_count is tied to zero and no counter flops exist
//
// Ports
//   clk            in   1   clock
//   rst_general    in   1   asynchronous active-high reset
//   run            in   1   level, free-run while high
//   step_pulse     in   1   one-cycle pulse, executes one instruction from IDLE
//   imem_addr      out  8   instruction memory address (equals pc)
//   imem_data      in  16   instruction memory data, valid 1 cycle after addr
//   take_branch    in   1   ALU branch condition, sampled in the last EXEC cycle
//   instruction    out 16   current instruction to the decoder
//   pc             out  8   current program counter
//   reg_we_strobe  out  1   commit pulse, high for the single COMMIT cycle
//   busy           out  1   high in FETCH, LATCH, EXEC, COMMIT
//   halted         out  1   high in HALT
//   retired_count  out 16   retired-instruction counter (optional feature)
// -----------------------------------------------------------------------------
module pdatapath_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         EXEC_CYCLES = 2,       // legal range 1..15
    parameter logic [3:0] OPC_BRANCH  = 4'b1000,
    parameter logic [3:0] OPC_HALT    = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_general,
    input  logic        run,
    input  logic        step_pulse,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    input  logic        take_branch,
    output logic [15:0] instruction,
    output logic [7:0]  pc,
    output logic        reg_we_strobe,
    output logic        busy,
    output logic        halted,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;
    // Branch decision captured in the final EXEC cycle and used in COMMIT.
    logic        br_taken_q, br_taken_d;

    logic [3:0]  opcode;
    assign opcode = instr_q[15:12];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_general) begin
        if (rst_general) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            exec_cnt_q <= 4'd0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            exec_cnt_q <= exec_cnt_d;
            br_taken_q <= br_taken_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        exec_cnt_d = exec_cnt_q;
        br_taken_d = br_taken_q;

        unique case (state_q)
            S_IDLE: begin
                // run and step_pulse together behave exactly like run.
                if (run || step_pulse) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Memory read of imem_addr is in flight this cycle.
                state_d = S_LATCH;
            end

            S_LATCH: begin
                instr_d    = imem_data;
                exec_cnt_d = EXEC_LOAD;
                state_d    = S_EXEC;
            end

            S_EXEC: begin
                if (exec_cnt_q == 4'd0) begin
                    br_taken_d = (opcode == OPC_BRANCH) && take_branch;
                    state_d    = (opcode == OPC_HALT) ? S_HALT : S_COMMIT;
                end else begin
                    exec_cnt_d = exec_cnt_q - 4'd1;
                end
            end

            S_COMMIT: begin
                // An 8-bit offset sign-extended to the 8-bit pc is the offset
                // itself, so modulo-256 addition gives the signed branch.
                pc_d    = pc_q + 8'd1 + (br_taken_q ? instr_q[7:0] : 8'd0);
                state_d = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                // Parked on the HALT word; only reset leaves this state.
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. All are decoded from registered state, so the asynchronous
    // reset clears the strobe immediately even in the middle of an instruction.
    // -------------------------------------------------------------------------
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instruction   = instr_q;
    assign reg_we_strobe = (state_q == S_COMMIT);
    assign busy          = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                           (state_q == S_EXEC)  || (state_q == S_COMMIT);
    assign halted        = (state_q == S_HALT);

`ifdef PDATAPATH_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_ff @(posedge clk or posedge rst_general) begin
        if (rst_general) begin
            retired_q <= 16'h0000;
        end else begin
            retired_q <= retired_d;
        end
    end

    // Counts COMMIT cycles only; HALT never passes through COMMIT.
    always_comb begin
        retired_d = retired_q;
        if ((state_q == S_COMMIT) && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pdatapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pdatapath_sequencer
//
// Bench for pdatapath_sequencer with default parameters. A registered ROM
// model supplies imem_data one cycle after imem_addr. A step-mode vector table
// walks the pc through branch, non-branch and wrap-around cases; directed
// sequences cover free-run to HALT, run dropping mid-instruction with an
// ignored step pulse, and reset in the last EXEC cycle. Every commit strobe is
// matched against a queue of expected {instruction, pc} records.
// -----------------------------------------------------------------------------
module tb_pdatapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_general;
    logic        run;
    logic        step_pulse;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        take_branch;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic        reg_we_strobe;
    logic        busy;
    logic        halted;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdatapath_sequencer dut (
        .clk           (clk),
        .rst_general   (rst_general),
        .run           (run),
        .step_pulse    (step_pulse),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .take_branch   (take_branch),
        .instruction   (instruction),
        .pc            (pc),
        .reg_we_strobe (reg_we_strobe),
        .busy          (busy),
        .halted        (halted),
        .retired_count (retired_count)
    );

    // Synchronous-read instruction memory.
    logic [15:0] rom [256];
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected commits.
    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } commit_t;
    commit_t exp_q[$];

    always @(negedge clk) begin
        if (!rst_general && reg_we_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: strobe at pc %0h with nothing expected", pc);
            end else begin
                commit_t e;
                e = exp_q.pop_front();
                chk("commit_instr", 32'(instruction), 32'(e.instr));
                chk("commit_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    // Step-mode vectors; each pc equals the previous vector's next pc.
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        take;
        logic [7:0]  next;
    } vec_t;
    vec_t vecs[14];

    task automatic do_reset();
        run         = 1'b0;
        step_pulse  = 1'b0;
        rst_general = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_general = 1'b0;
    endtask

    // Pulse step_pulse across one edge, then wait (bounded) for the strobe.
    // lat is the number of cycles after the sampling edge, -1 on timeout.
    task automatic do_step(input logic [15:0] ins, output int lat);
        @(negedge clk);
        step_pulse = 1'b1;
        @(posedge clk);
        #1 step_pulse = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) chk("instr_at_t3", 32'(instruction), 32'(ins));
            if (reg_we_strobe) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin : main
        int lat;
        int last;
        int nstrobe;

        vecs[0]  = '{8'h00, 16'h1234, 1'b0, 8'h01};
        vecs[1]  = '{8'h01, 16'h8003, 1'b0, 8'h02};
        vecs[2]  = '{8'h02, 16'h8002, 1'b1, 8'h05};
        vecs[3]  = '{8'h05, 16'h80FC, 1'b0, 8'h06};
        vecs[4]  = '{8'h06, 16'h80FE, 1'b1, 8'h05};
        vecs[5]  = '{8'h05, 16'h80FC, 1'b1, 8'h02};
        vecs[6]  = '{8'h02, 16'h0002, 1'b1, 8'h03};
        vecs[7]  = '{8'h03, 16'h800C, 1'b1, 8'h10};
        vecs[8]  = '{8'h10, 16'h8080, 1'b1, 8'h91};
        vecs[9]  = '{8'h91, 16'h805E, 1'b1, 8'hF0};
        vecs[10] = '{8'hF0, 16'h8020, 1'b1, 8'h11};
        vecs[11] = '{8'h11, 16'h80ED, 1'b1, 8'hFF};
        vecs[12] = '{8'hFF, 16'h7ABC, 1'b0, 8'h00};
        vecs[13] = '{8'h00, 16'h9001, 1'b1, 8'h01};

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        take_branch = 1'b0;

        // ---- reset state --------------------------------------------------
        run         = 1'b0;
        step_pulse  = 1'b0;
        rst_general = 1'b1;
        #1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_strobe", 32'(reg_we_strobe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_retired", 32'(retired_count), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_general = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // ---- step-mode vector table ---------------------------------------
        foreach (vecs[i]) begin
            rom[vecs[i].pc] = vecs[i].instr;
            take_branch     = vecs[i].take;
            chk("vec_pc_before", 32'(pc), 32'(vecs[i].pc));
            chk("vec_imem_addr", 32'(imem_addr), 32'(vecs[i].pc));
            exp_q.push_back('{vecs[i].instr, vecs[i].pc});
            do_step(vecs[i].instr, lat);
            chk("vec_latency", 32'(lat), 32'd5);
            @(negedge clk);
            chk("vec_pc_next", 32'(pc), 32'(vecs[i].next));
            chk("vec_idle_busy", 32'(busy), 32'h0);
            chk("vec_instr_hold", 32'(instruction), 32'(vecs[i].instr));
        end
        take_branch = 1'b0;

        // ---- free run into HALT -------------------------------------------
        do_reset();
        rom[0] = 16'h1001;
        rom[1] = 16'h2002;
        rom[2] = 16'h3003;
        rom[3] = 16'hF000;
        for (int i = 0; i < 3; i++) exp_q.push_back('{rom[i], 8'(i)});
        @(negedge clk);
        run     = 1'b1;
        last    = -1;
        nstrobe = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (reg_we_strobe) begin
                if (last >= 0) chk("run_spacing", 32'(k - last), 32'd5);
                last = k;
                nstrobe++;
            end
            if (halted) break;
        end
        chk("run_halted", 32'(halted), 32'h1);
        chk("run_strobes", 32'(nstrobe), 32'd3);
        repeat (10) @(negedge clk);
        step_pulse = 1'b1;
        @(negedge clk);
        step_pulse = 1'b0;
        repeat (10) @(negedge clk);
        chk("halt_pc", 32'(pc), 32'h03);
        chk("halt_instr", 32'(instruction), 32'hF000);
        chk("halt_stays", 32'(halted), 32'h1);
        chk("halt_busy", 32'(busy), 32'h0);
`ifdef PDATAPATH_SEQ_RETIRE_CNT_EN
        chk("halt_retired", 32'(retired_count), 32'd3);
`else
        chk("halt_retired", 32'(retired_count), 32'd0);
`endif

        // ---- run drops during EXEC, step pulse ignored --------------------
        do_reset();
        chk("post_halt_rst", 32'(halted), 32'h0);
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        exp_q.push_back('{16'h1111, 8'h00});
        run = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);   // first EXEC cycle
        chk("drop_busy_exec", 32'(busy), 32'h1);
        run        = 1'b0;
        step_pulse = 1'b1;
        @(negedge clk);
        step_pulse = 1'b0;
        repeat (15) @(negedge clk);
        chk("drop_pc", 32'(pc), 32'h01);
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_instr", 32'(instruction), 32'h1111);

        // ---- reset in the last EXEC cycle ---------------------------------
        do_reset();
        rom[0] = 16'h3333;
        @(negedge clk);
        step_pulse = 1'b1;
        @(posedge clk);
        #1 step_pulse = 1'b0;
        repeat (4) @(negedge clk);   // last EXEC cycle
        chk("mid_instr_before", 32'(instruction), 32'h3333);
        chk("mid_strobe_before", 32'(reg_we_strobe), 32'h0);
        rst_general = 1'b1;
        #1;
        chk("mid_rst_strobe", 32'(reg_we_strobe), 32'h0);
        chk("mid_rst_pc", 32'(pc), 32'h00);
        chk("mid_rst_instr", 32'(instruction), 32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_general = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_after_busy", 32'(busy), 32'h0);
        chk("mid_after_pc", 32'(pc), 32'h00);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
